fft_sample_collector: RTL and testbench
=======================================

Name: fft_sample_collector

Overview:
Upstream stage of full_parallel_fft: serial-to-parallel frame builder. Accepts one complex sample per cycle and packs 2^NPOINT samples into one frame. Uses a ping-pong double buffer, so input streaming continues while the previous frame waits for the FFT. Presents the frame on the packed din_real/din_imag bus of full_parallel_fft with the same valid/busy handshake.

Parameters:
NPOINT, 3, log2 of FFT points per frame (frame = 2^NPOINT samples)
WIDTH, 16, bits per real or imaginary component, two's complement

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
sin_valid  input  1  serial sample valid
sin_busy  output  1  collector cannot accept; sample transfers only when sin_valid && !sin_busy
sin_real  input  WIDTH  serial sample real part
sin_imag  input  WIDTH  serial sample imaginary part
dout_valid  output  1  full frame presented
dout_busy  input  1  FFT stall; frame transfers only when dout_valid && !dout_busy
dout_real  output  WIDTH*2^NPOINT  packed frame real, slot i at [i*WIDTH +: WIDTH]
dout_imag  output  WIDTH*2^NPOINT  packed frame imaginary, same packing

Behaviour:
- Storage: two banks (0/1), each 2^NPOINT x 2*WIDTH, each with a full flag. Pointers wr_sel and rd_sel (1 bit each). Write counter cnt is NPOINT bits.
- Reset (async, rst_n=0): cnt=0, wr_sel=rd_sel=0, both full flags=0, all bank contents=0. Outputs: sin_busy=0, dout_valid=0, dout_real=dout_imag=0. A reset mid-frame discards the partial frame; the next frame starts at slot 0.
- Input accept (sin_valid && !sin_busy): sample written to bank[wr_sel] slot map(cnt), then cnt increments.
- Wrap: when cnt==2^NPOINT-1 on accept:
  - full[wr_sel] set to 1
  - wr_sel toggles
  - cnt wraps to 0
- sin_busy = full[wr_sel], combinational from registers. It asserts only when both banks are full and the next write bank is occupied.
- dout_valid = full[rd_sel]. dout_real/dout_imag = bank[rd_sel] contents, driven directly from storage and stable while dout_valid=1.
- Output transfer (dout_valid && !dout_busy): full[rd_sel] cleared, rd_sel toggles.
- Latency: frame visible (dout_valid=1) on the cycle after its last sample is accepted.
- Throughput: 1 sample/cycle sustained while the FFT consumes one frame per 2^NPOINT cycles.
- Simultaneous fill-complete and drain in the same cycle: they always target different banks; both take effect.
- Both banks full and a drain occurs: sin_busy stays 1 that cycle and drops the following cycle. No sample is lost or overwritten.
- Frame order: output order equals fill order. Bank 0 is always the first frame after reset.
- No arithmetic on data. Samples are stored bit-exact.

Optional Feature:
FSC_BITREV_EN:
- Defined: map(cnt) = bit-reversal of cnt over NPOINT bits. The frame is delivered in bit-reversed order for a DIT FFT.
- Undefined: map(cnt) = cnt, natural order.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> sin_busy=0, dout_valid=0, dout_real=dout_imag=0. Release -> values unchanged until the first full frame.
- Single frame, NPOINT=3, WIDTH=16, dout_busy=0: feed real=k*100, imag=-k for k=0..7 on consecutive cycles.
  - dout_valid=1 on the cycle after k=7.
  - Natural build: slot i real=i*100.
  - FSC_BITREV_EN build: slots 0..7 real = 0,400,200,600,100,500,300,700; imag = 0,-4,-2,-6,-1,-5,-3,-7.
- Backpressure: dout_busy=1, stream 17 samples.
  - sin_busy=1 after the 16th accept; 17th sample held.
  - Release dout_busy -> frame A (samples 0-7) transfers first, then frame B (8-15).
  - sin_busy=0 one cycle after the first drain; 17th sample accepted as slot 0 of frame C.
- Simultaneous: drain frame A on the same cycle the last sample of frame B is accepted -> next cycle dout_valid=1 with frame B, no data lost.
- Reset mid-frame: accept 5 samples, pulse rst_n low, then feed 8 samples 1000..1007 -> single frame equals 1000..1007 (mapped). The partial frame never appears.
- Gapped input: sin_valid random 50% duty over 24 samples with dout_busy toggling -> three frames, in order, bit-exact against the reference model.

Source files
------------

// File: rtl/fft_sample_collector.sv
// fft_sample_collector: serial-to-parallel frame builder feeding full_parallel_fft.
// Accepts one complex sample per cycle into a ping-pong pair of banks. A full bank
// is presented on the packed dout bus while the other bank keeps filling.
// Optional build macro: FSC_BITREV_EN -- when defined, samples are stored at the
// bit-reversed slot of their arrival index (DIT input order); otherwise natural order.
//
// Handshake (both sides): a transfer happens on a rising clk edge when valid is high
// and busy is low in that cycle; the sender holds data stable while valid && busy.
module fft_sample_collector #(
  parameter int NPOINT = 3,
  parameter int WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sin_valid,
  output logic                            sin_busy,
  input  logic [WIDTH-1:0]                sin_real,
  input  logic [WIDTH-1:0]                sin_imag,
  output logic                            dout_valid,
  input  logic                            dout_busy,
  output logic [WIDTH*(2**NPOINT)-1:0]    dout_real,
  output logic [WIDTH*(2**NPOINT)-1:0]    dout_imag
);

  localparam int NSAMP = 2 ** NPOINT;
  localparam logic [NPOINT-1:0] CNT_LAST = '1;
  localparam logic [NPOINT-1:0] CNT_ONE  = NPOINT'(1);

  // Arrival index -> storage slot.
  function automatic logic [NPOINT-1:0] slot_map(input logic [NPOINT-1:0] c);
    logic [NPOINT-1:0] r;
`ifdef FSC_BITREV_EN
    for (int b = 0; b < NPOINT; b++) begin
      r[b] = c[NPOINT-1-b];
    end
`else
    r = c;
`endif
    return r;
  endfunction

  // Ping-pong storage and control state.
  logic [WIDTH-1:0]  bank_re_q [0:1][0:NSAMP-1];
  logic [WIDTH-1:0]  bank_im_q [0:1][0:NSAMP-1];
  logic [WIDTH-1:0]  bank_re_d [0:1][0:NSAMP-1];
  logic [WIDTH-1:0]  bank_im_d [0:1][0:NSAMP-1];
  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [NPOINT-1:0] cnt_q, cnt_d;

  logic              accept;
  logic              drain;
  logic [NPOINT-1:0] wr_slot;

  // Handshake outputs come straight from the flags: no combinational path from inputs.
  always_comb begin
    sin_busy   = full_q[wr_sel_q];
    dout_valid = full_q[rd_sel_q];
    accept     = sin_valid && !sin_busy;
    drain      = dout_valid && !dout_busy;
    wr_slot    = slot_map(cnt_q);
  end

  // Next-state for pointers, counter and full flags. A completing fill and a drain
  // in the same cycle always address different banks, so both updates apply.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    cnt_d    = cnt_q;
    if (accept) begin
      if (cnt_q == CNT_LAST) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        cnt_d            = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    if (drain) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  // Next-state for the sample banks: only the addressed slot of the write bank changes.
  always_comb begin
    bank_re_d = bank_re_q;
    bank_im_d = bank_im_q;
    if (accept) begin
      bank_re_d[wr_sel_q][wr_slot] = sin_real;
      bank_im_d[wr_sel_q][wr_slot] = sin_imag;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      cnt_q    <= cnt_d;
    end
  end

  // Bank storage register; cleared on reset so the output bus reads zero until a frame lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < NSAMP; s++) begin
          bank_re_q[b][s] <= '0;
          bank_im_q[b][s] <= '0;
        end
      end
    end else begin
      bank_re_q <= bank_re_d;
      bank_im_q <= bank_im_d;
    end
  end

  // Present the read bank on the packed bus, slot i at [i*WIDTH +: WIDTH].
  always_comb begin
    dout_real = '0;
    dout_imag = '0;
    for (int s = 0; s < NSAMP; s++) begin
      dout_real[s*WIDTH +: WIDTH] = bank_re_q[rd_sel_q][s];
      dout_imag[s*WIDTH +: WIDTH] = bank_im_q[rd_sel_q][s];
    end
  end

endmodule

// File: tb/tb_fft_sample_collector.sv
// Bench for fft_sample_collector: driver tasks push accepted samples into a frame
// reference model; completed frames land in exp_q and a negedge monitor pops and
// compares every frame the DUT hands over.
module tb_fft_sample_collector;

  localparam int NP = 3;
  localparam int W  = 16;
  localparam int N  = 1 << NP;
  localparam int FW = W * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          sin_valid = 1'b0;
  logic          sin_busy;
  logic [W-1:0]  sin_real = '0;
  logic [W-1:0]  sin_imag = '0;
  logic          dout_valid;
  logic          dout_busy = 1'b0;
  logic [FW-1:0] dout_real;
  logic [FW-1:0] dout_imag;

  fft_sample_collector #(.NPOINT(NP), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin_valid  (sin_valid),
    .sin_busy   (sin_busy),
    .sin_real   (sin_real),
    .sin_imag   (sin_imag),
    .dout_valid (dout_valid),
    .dout_busy  (dout_busy),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag)
  );

  // ---------------- counters / checks ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2*FW-1:0] exp_q[$];   // {real_frame, imag_frame}
  logic [W-1:0]    pend_re[$];
  logic [W-1:0]    pend_im[$];

  // Slot where the k-th arrival of a frame should land.
  function automatic int ref_slot(input int k);
    int r;
`ifdef FSC_BITREV_EN
    r = 0;
    for (int b = 0; b < NP; b++) begin
      if (((k >> b) & 1) == 1) r = r + (1 << (NP - 1 - b));
    end
`else
    r = k;
`endif
    return r;
  endfunction

  task automatic model_push(input logic [W-1:0] re, input logic [W-1:0] im);
    logic [FW-1:0] fr, fi;
    pend_re.push_back(re);
    pend_im.push_back(im);
    if (pend_re.size() == N) begin
      fr = '0;
      fi = '0;
      for (int k = 0; k < N; k++) begin
        fr[ref_slot(k)*W +: W] = pend_re[k];
        fi[ref_slot(k)*W +: W] = pend_im[k];
      end
      exp_q.push_back({fr, fi});
      pend_re.delete();
      pend_im.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int drain_cyc_q[$];

  always @(negedge clk) begin
    if (rst_n && dout_valid && !dout_busy) begin
      drain_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame: got real %h with no frame expected", dout_real);
      end else begin
        logic [2*FW-1:0] e;
        e = exp_q.pop_front();
        check("frame_real", dout_real, e[2*FW-1:FW]);
        check("frame_imag", dout_imag, e[FW-1:0]);
      end
    end
  end

  // Random FFT stall generator for the gapped test.
  bit rand_busy_en = 1'b0;
  always @(posedge clk) begin
    if (rand_busy_en) begin
      #1 dout_busy = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  int accept_cyc = 0;

  // Offer one sample and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
    bit ok = 1'b0;
    sin_valid = 1'b1;
    sin_real  = re;
    sin_imag  = im;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!sin_busy) begin
        ok = 1'b1;
        accept_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin_real  = W'($urandom);
    sin_imag  = W'($urandom);
    if (ok) model_push(re, im);
    else begin
      tests++;
      fails++;
      $display("FAIL send_timeout: sample %h never accepted", re);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sin_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Let every expected frame drain, bounded.
  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !dout_valid) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL drain_timeout: %0d frames still expected, dout_valid=%0b", exp_q.size(), dout_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend_re.delete();
    pend_im.delete();
    repeat (3) begin
      sin_valid = 1'($urandom_range(0, 1));
      sin_real  = W'($urandom);
      sin_imag  = W'($urandom);
      @(negedge clk);
      check("rst_sin_busy", FW'(sin_busy), '0);
      check("rst_dout_valid", FW'(dout_valid), '0);
      check("rst_dout_real", dout_real, '0);
      check("rst_dout_imag", dout_imag, '0);
    end
    sin_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] r16;
    // Reset with random inputs, then confirm idle outputs after release.
    do_reset();
    dout_busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_valid", FW'(dout_valid), '0);
      check("post_rst_busy", FW'(sin_busy), '0);
      check("post_rst_real", dout_real, '0);
    end
    @(posedge clk);
    #1;
    dout_busy = 1'b0;

    // Single frame: real=k*100, imag=-k.
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) begin
        @(negedge clk);
        check("no_early_valid", FW'(dout_valid), '0);
        @(posedge clk);
        #1;
      end
      send(W'(k * 100), W'(-k));
    end
    @(negedge clk);
    check("single_latency_valid", FW'(dout_valid), FW'(1));
`ifdef FSC_BITREV_EN
    check("single_slot1_real", FW'(dout_real[W +: W]), FW'(400));
`else
    check("single_slot1_real", FW'(dout_real[W +: W]), FW'(100));
`endif
    @(posedge clk);
    #1;
    wait_drain();

    // Backpressure: 17 samples with the FFT stalled.
    dout_busy = 1'b1;
    for (int k = 0; k < 2 * N; k++) send(W'(16'h2000 + k), W'($urandom));
    @(negedge clk);
    check("bp_busy_after_16", FW'(sin_busy), FW'(1));
    drain_cyc_q.delete();
    fork
      send(W'(16'h2010), W'(16'h7777));
      begin
        repeat (4) @(negedge clk);
        check("bp_17th_held", FW'(pend_re.size()), '0);
        check("bp_busy_held", FW'(sin_busy), FW'(1));
        @(posedge clk);
        #1;
        dout_busy = 1'b0;
      end
    join
    tests++;
    if (drain_cyc_q.size() == 0 || accept_cyc != drain_cyc_q[0] + 1) begin
      fails++;
      $display("FAIL bp_accept_timing: accept cycle %0d, first drain cycle %0d",
               accept_cyc, (drain_cyc_q.size() != 0) ? drain_cyc_q[0] : -1);
    end
    for (int k = 1; k < N; k++) send(W'(16'h2010 + k), W'($urandom));
    wait_drain();

    // Simultaneous drain of A with last-sample accept of B.
    dout_busy = 1'b1;
    for (int k = 0; k < 2 * N - 1; k++) send(W'($urandom), W'($urandom));
    drain_cyc_q.delete();
    dout_busy = 1'b0;
    send(W'(16'h5A5A), W'(16'hA5A5));
    tests++;
    if (drain_cyc_q.size() == 0 || drain_cyc_q[0] != accept_cyc) begin
      fails++;
      $display("FAIL simul_same_cycle: accept cycle %0d, drain cycle %0d",
               accept_cyc, (drain_cyc_q.size() != 0) ? drain_cyc_q[0] : -1);
    end
    @(negedge clk);
    check("simul_next_valid", FW'(dout_valid), FW'(1));
    @(posedge clk);
    #1;
    wait_drain();

    // Reset mid-frame discards the partial frame.
    for (int k = 0; k < 5; k++) send(W'($urandom), W'($urandom));
    do_reset();
    for (int k = 0; k < N; k++) send(W'(1000 + k), W'(-(1000 + k)));
    wait_drain();

    // Gapped input with random FFT stalls: three frames.
    rand_busy_en = 1'b1;
    for (int k = 0; k < 3 * N; k++) begin
      while ($urandom_range(0, 1) == 1) idle(1);
      r16 = W'($urandom);
      send(r16, W'($urandom));
    end
    rand_busy_en = 1'b0;
    @(posedge clk);
    #2;
    dout_busy = 1'b0;
    wait_drain();

    check("final_queue_empty", FW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
